wb_stage: RTL

Write-back stage feeding the integer register file (x0–x31, 64-bit). It merges single-cycle ALU results with load results from the memory stage. Load data is sign/zero-extended and stored in a small load queue. The stage arbitrates one register write per cycle and drives the register file's write port (`WriteAddr`/`WriteData`/`RegWrite`) from registers. It also exposes a forwarding copy of the write in flight and a pending-write hazard check for the decode stage.

---
 rtl/riscv_wb_pkg.sv | 19 +
 rtl/ld_align_ext.sv | 32 +++
 rtl/wb_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared widths, load funct3 encodings and load-queue entry layout for the
// integer write-back stage.
package riscv_wb_pkg;
   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } lq_entry_t;
endpackage

// File: rtl/ld_align_ext.sv
// Load formatter: shifts the addressed bytes down to bit 0, then sign- or
// zero-extends them according to the load type. Funct3 111 is flagged illegal.
module ld_align_ext
   import riscv_wb_pkg::*;
(
   input  logic [XLEN-1:0] ld_raw,
   input  logic [2:0]      ld_addr_lo,
   input  logic [2:0]      ld_funct3,
   output logic [XLEN-1:0] data,
   output logic            illegal
);

   logic [XLEN-1:0] s;

   assign s = ld_raw >> {ld_addr_lo, 3'b000};

   always_comb begin
      data    = '0;
      illegal = 1'b0;
      case (ld_funct3)
         F3_LB:   data = {{(XLEN-8){s[7]}}, s[7:0]};
         F3_LH:   data = {{(XLEN-16){s[15]}}, s[15:0]};
         F3_LW:   data = {{(XLEN-32){s[31]}}, s[31:0]};
         F3_LD:   data = s;
         F3_LBU:  data = {{(XLEN-8){1'b0}}, s[7:0]};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, s[15:0]};
         F3_LWU:  data = {{(XLEN-32){1'b0}}, s[31:0]};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load queue, one-write-per-cycle arbiter (full queue beats
// ALU beats non-empty queue), registered register-file port and hazard compare.
module wb_stage
   import riscv_wb_pkg::*;
#(
   parameter int LQ_DEPTH = 4
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [XLEN-1:0]   ld_raw,
   input  logic [2:0]        ld_addr_lo,
   input  logic [2:0]        ld_funct3,
   output logic              ld_err,
   output logic [REG_AW-1:0] WriteAddr,
   output logic [XLEN-1:0]   WriteData,
   output logic              RegWrite,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [XLEN-1:0]   fwd_data,
   input  logic [REG_AW-1:0] hz_rd,
   output logic              hz_hit
);

   localparam int         PW    = $clog2(LQ_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(LQ_DEPTH);
   localparam logic [PW:0] ONE  = (PW+1)'(1);

   lq_entry_t         lq [LQ_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count;
   logic              full, push, pop, alu_take, wr_sel;
   logic [XLEN-1:0]   fmt_data;
   logic              fmt_illegal;
   logic [REG_AW-1:0] wr_rd;
   logic [XLEN-1:0]   wr_data;
   logic [LQ_DEPTH-1:0] hit_vec;

   ld_align_ext u_align (
      .ld_raw     (ld_raw),
      .ld_addr_lo (ld_addr_lo),
      .ld_funct3  (ld_funct3),
      .data       (fmt_data),
      .illegal    (fmt_illegal)
   );

   assign full      = (count == FULL);
   assign ld_ready  = !rst && !full;
   assign alu_ready = !rst && !full;
   assign push      = ld_valid && ld_ready && !fmt_illegal;

   // A full queue must drain or the load path would deadlock behind ALU traffic.
   assign pop      = !rst && (full || (!alu_valid && count != '0));
   assign alu_take = !rst && !full && alu_valid;
   assign wr_sel   = pop || alu_take;
   assign wr_rd    = pop ? lq[rd_ptr].rd   : alu_rd;
   assign wr_data  = pop ? lq[rd_ptr].data : alu_data;

   always_ff @(posedge sys_clk) begin
      if (push) lq[wr_ptr] <= '{rd: ld_rd, data: fmt_data};
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         RegWrite  <= 1'b0;
         WriteAddr <= '0;
         WriteData <= '0;
         ld_err    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + ONE;
         else if (pop && !push) count <= count - ONE;
         RegWrite <= wr_sel && (wr_rd != '0);
         if (wr_sel) begin
            WriteAddr <= wr_rd;
            WriteData <= wr_data;
         end
         ld_err <= ld_valid && ld_ready && fmt_illegal;
      end
   end

   assign fwd_valid = RegWrite;
   assign fwd_rd    = WriteAddr;
   assign fwd_data  = WriteData;

   // Entry i is live when its distance from the head is below the count.
   for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_hz
      logic [PW-1:0] off;
      assign off        = PW'(i) - rd_ptr;
      assign hit_vec[i] = ({1'b0, off} < count) && (lq[i].rd == hz_rd);
   end

   assign hz_hit = !rst && (hz_rd != '0) && (|hit_vec);

endmodule
